// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding,
// datapath widths and the sequential PC increment.
package pipe_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MEM  = 2'd2,
    HAZ  = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of fetch/decode control signals between the pipeline and pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic             start_i;
  logic [XLEN-1:0]  pc_i;
  logic             branch_i;
  logic [XLEN-1:0]  branch_target_i;
  logic             jump_i;
  logic [XLEN-1:0]  jump_target_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             mem_stall_i;
  logic [XLEN-1:0]  pc_next_o;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic [1:0]       state_o;
  logic [15:0]      stall_cnt_o;
  logic [15:0]      redir_cnt_o;

  modport master (
    output start_i, pc_i, branch_i, branch_target_i, jump_i, jump_target_i,
           idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, mem_stall_i,
    input  pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           state_o, stall_cnt_o, redir_cnt_o
  );

  modport slave (
    input  start_i, pc_i, branch_i, branch_target_i, jump_i, jump_target_i,
           idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, mem_stall_i,
    output pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           state_o, stall_cnt_o, redir_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds an ID source.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             memread,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt_id,
  output logic             lu
);

  // Register 0 is hard-wired to zero, so a load into it never creates a hazard.
  assign lu = memread && (rt != '0) && ((rt == rs) || (rt == rt_id));

endmodule

// File: rtl/pipe_ctrl_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= 16'd0;
    end else if (inc_i && (cnt_o != 16'hFFFF)) begin
      cnt_o <= cnt_o + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch/decode controller: selects the next PC and drives stall, bubble and
// flush controls from a small RUN/MEM/HAZ state machine.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_ctrl_if.slave  bus
);

  state_e          state_q;
  state_e          state_d;
  logic            lu;
  logic            stall_inc;
  logic [XLEN-1:0] pc_next;
  logic            pc_write;
  logic            ifid_write;
  logic            ifid_flush;
  logic            idex_bubble;
  logic [15:0]     stall_cnt;
  logic [15:0]     redir_cnt;

  hazard_detect u_hazard (
    .memread (bus.idex_memread_i),
    .rt      (bus.idex_rt_i),
    .rs      (bus.ifid_rs_i),
    .rt_id   (bus.ifid_rt_i),
    .lu      (lu)
  );

  // HAZ evaluates exactly like RUN; it only exists so the bubble cycle is visible.
  always_comb begin
    state_d     = state_q;
    pc_next     = bus.pc_i;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      MEM: begin
        if (bus.mem_stall_i) stall_inc = 1'b1;
        else                 state_d   = RUN;
      end
      RUN, HAZ: begin
        if (!bus.start_i) begin
          state_d = IDLE;
        end else if (bus.mem_stall_i) begin
          state_d   = MEM;
          stall_inc = 1'b1;
        end else if (lu) begin
          state_d     = HAZ;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          state_d    = RUN;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (bus.jump_i) begin
            pc_next    = bus.jump_target_i;
            ifid_flush = 1'b1;
          end else if (bus.branch_i) begin
            pc_next    = bus.branch_target_i;
            ifid_flush = 1'b1;
          end else begin
            pc_next = bus.pc_i + PC_STEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  sat_cnt16 u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_cnt16 u_redir_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifid_flush),
    .cnt_o (redir_cnt)
  );

  assign bus.pc_next_o     = pc_next;
  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.state_o       = state_q;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.redir_cnt_o   = redir_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the fetch controller's per-cycle rules.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int   m_mode;
  int   m_stall;
  int   m_redir;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start_i         = 1'b0;
    bus.pc_i            = 32'd0;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'd0;
    bus.jump_i          = 1'b0;
    bus.jump_target_i   = 32'd0;
    bus.idex_memread_i  = 1'b0;
    bus.idex_rt_i       = 5'd0;
    bus.ifid_rs_i       = 5'd0;
    bus.ifid_rt_i       = 5'd0;
    bus.mem_stall_i     = 1'b0;
  endtask

  // Mode numbers: 0 idle, 1 running, 2 waiting on memory, 3 load-use bubble.
  function automatic void ref_cycle(input int mode, output logic [31:0] pn,
                                    output logic [3:0] ctl, output int next_mode,
                                    output bit stalled);
    bit load_use;
    bit pw, iw, fl, bb;
    load_use = bus.idex_memread_i && (bus.idex_rt_i != 0) &&
               (bus.idex_rt_i == bus.ifid_rs_i || bus.idex_rt_i == bus.ifid_rt_i);
    pn = bus.pc_i;
    {pw, iw, fl, bb} = 4'b0000;
    next_mode = mode;
    stalled = 0;
    if (mode == 2) begin
      stalled   = bus.mem_stall_i;
      next_mode = bus.mem_stall_i ? 2 : 1;
    end else if (!bus.start_i) begin
      next_mode = 0;
    end else if (mode == 0) begin
      next_mode = 1;
    end else if (bus.mem_stall_i) begin
      next_mode = 2;
      stalled   = 1;
    end else if (load_use) begin
      bb = 1; next_mode = 3; stalled = 1;
    end else begin
      pw = 1; iw = 1; next_mode = 1;
      if (bus.jump_i || bus.branch_i) begin
        fl = 1;
        pn = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
      end else begin
        pn = bus.pc_i + 32'd4;
      end
    end
    ctl = {pw, iw, fl, bb};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.pc_i = 32'h0000_1234;
    #1;
    checks++;
    if (bus.state_o !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state_o);
    end
    checks++;
    if ({bus.stall_cnt_o, bus.redir_cnt_o} !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %0h/%0h expected 0/0", bus.stall_cnt_o, bus.redir_cnt_o);
    end
    checks++;
    if (bus.pc_next_o !== 32'h0000_1234 || bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_outputs: got pc_next %0h pw %0b iw %0b expected 1234 0 0", bus.pc_next_o, bus.pc_write_o, bus.ifid_write_o);
    end
    tick();
    tick();
  endtask

  task automatic test_start();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.state_o !== 2'd0) begin
      errors++; $display("[TB] FAIL idle_without_start: got %0d expected 0", bus.state_o);
    end
    bus.start_i = 1'b1;
    bus.pc_i    = 32'd0;
    tick();
    checks++;
    if (bus.state_o !== 2'd1) begin
      errors++; $display("[TB] FAIL start_to_run: got %0d expected 1", bus.state_o);
    end
    checks++;
    if (bus.pc_next_o !== 32'd4 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL first_fetch: got pc_next %0h pw %0b expected 4 1", bus.pc_next_o, bus.pc_write_o);
    end
  endtask

  task automatic test_load_use();
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd5;
    bus.ifid_rs_i      = 5'd5;
    bus.ifid_rt_i      = 5'd0;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b0 || bus.idex_bubble_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_use_ctl: got pw %0b bubble %0b expected 0 1", bus.pc_write_o, bus.idex_bubble_o);
    end
    tick();
    checks++;
    if (bus.state_o !== 2'd3 || bus.stall_cnt_o !== 16'd1) begin
      errors++; $display("[TB] FAIL load_use_haz: got state %0d stall %0d expected 3 1", bus.state_o, bus.stall_cnt_o);
    end
    bus.idex_rt_i = 5'd0;
    bus.ifid_rs_i = 5'd0;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin
      errors++; $display("[TB] FAIL r0_no_stall: got pw %0b bubble %0b expected 1 0", bus.pc_write_o, bus.idex_bubble_o);
    end
    tick();
    bus.idex_memread_i = 1'b0;
  endtask

  task automatic test_mem_stall();
    bus.mem_stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin
        errors++; $display("[TB] FAIL mem_stall_ctl%0d: got pw %0b iw %0b expected 0 0", k, bus.pc_write_o, bus.ifid_write_o);
      end
      tick();
      checks++;
      if (bus.state_o !== 2'd2) begin
        errors++; $display("[TB] FAIL mem_state%0d: got %0d expected 2", k, bus.state_o);
      end
    end
    checks++;
    if (bus.stall_cnt_o !== 16'd4) begin
      errors++; $display("[TB] FAIL mem_stall_count: got %0d expected 4", bus.stall_cnt_o);
    end
    bus.mem_stall_i = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd1) begin
      errors++; $display("[TB] FAIL mem_release: got %0d expected 1", bus.state_o);
    end
  endtask

  task automatic test_redirect();
    bus.jump_i          = 1'b1;
    bus.jump_target_i   = 32'h100;
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'h200;
    #1;
    checks++;
    if (bus.pc_next_o !== 32'h100 || bus.ifid_flush_o !== 1'b1) begin
      errors++; $display("[TB] FAIL jump_wins: got pc_next %0h flush %0b expected 100 1", bus.pc_next_o, bus.ifid_flush_o);
    end
    tick();
    checks++;
    if (bus.redir_cnt_o !== 16'd1) begin
      errors++; $display("[TB] FAIL redir_count1: got %0d expected 1", bus.redir_cnt_o);
    end
    bus.jump_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_next_o !== 32'h200 || bus.ifid_flush_o !== 1'b1) begin
      errors++; $display("[TB] FAIL branch_target: got pc_next %0h flush %0b expected 200 1", bus.pc_next_o, bus.ifid_flush_o);
    end
    tick();
    bus.branch_i = 1'b0;
  endtask

  task automatic test_wrap();
    bus.pc_i = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (bus.pc_next_o !== 32'd0 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("[TB] FAIL pc_wrap: got pc_next %0h pw %0b expected 0 1", bus.pc_next_o, bus.pc_write_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_mem();
    bus.mem_stall_i = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 2'd0 || bus.stall_cnt_o !== 16'd0 || bus.redir_cnt_o !== 16'd0) begin
      errors++; $display("[TB] FAIL async_reset_mem: got state %0d stall %0d redir %0d expected 0 0 0", bus.state_o, bus.stall_cnt_o, bus.redir_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_stall_i = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd1) begin
      errors++; $display("[TB] FAIL restart_run: got %0d expected 1", bus.state_o);
    end
    bus.start_i = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pc_write_o !== 1'b0) begin
      errors++; $display("[TB] FAIL stop_to_idle: got state %0d pw %0b expected 0 0", bus.state_o, bus.pc_write_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pn;
    logic [3:0]  exp_ctl;
    logic [3:0]  got_ctl;
    int          nxt;
    bit          stalled;
    rst = 1'b0;
    clear_inputs();
    #1;
    @(negedge clk);
    rst = 1'b1;
    m_mode = 0; m_stall = 0; m_redir = 0;
    for (int i = 0; i < 400; i++) begin
      bus.start_i         = ($urandom_range(0, 15) != 0);
      bus.mem_stall_i     = ($urandom_range(0, 3) == 0);
      bus.idex_memread_i  = ($urandom_range(0, 1) == 1);
      bus.idex_rt_i       = 5'($urandom_range(0, 3));
      bus.ifid_rs_i       = 5'($urandom_range(0, 3));
      bus.ifid_rt_i       = 5'($urandom_range(0, 3));
      bus.jump_i          = ($urandom_range(0, 3) == 0);
      bus.branch_i        = ($urandom_range(0, 3) == 0);
      bus.jump_target_i   = $urandom;
      bus.branch_target_i = $urandom;
      bus.pc_i            = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      #1;
      ref_cycle(m_mode, exp_pn, exp_ctl, nxt, stalled);
      got_ctl = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_bubble_o};
      checks++;
      if (bus.pc_next_o !== exp_pn) begin
        errors++; $display("[TB] FAIL rand_pc_next @%0d: got %0h expected %0h", i, bus.pc_next_o, exp_pn);
      end
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++; $display("[TB] FAIL rand_ctl @%0d: got %b expected %b", i, got_ctl, exp_ctl);
      end
      checks++;
      if (int'(bus.state_o) != m_mode) begin
        errors++; $display("[TB] FAIL rand_state @%0d: got %0d expected %0d", i, bus.state_o, m_mode);
      end
      checks++;
      if (int'(bus.stall_cnt_o) != m_stall || int'(bus.redir_cnt_o) != m_redir) begin
        errors++; $display("[TB] FAIL rand_counters @%0d: got %0d/%0d expected %0d/%0d", i, bus.stall_cnt_o, bus.redir_cnt_o, m_stall, m_redir);
      end
      tick();
      m_mode = nxt;
      if (stalled && m_stall < 65535) m_stall++;
      if (exp_ctl[1] && m_redir < 65535) m_redir++;
    end
  endtask

  initial begin
    $display("[TB] pipe_ctrl bench starting");
    test_reset();
    test_start();
    test_load_use();
    test_mem_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL expose these ports: clk_i  in  1  clock, rising-edge.
REQ-002 The block SHALL expose these ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose these ports: start_i  in  1  run enable; low freezes fetch.
REQ-004 The block SHALL expose these ports: pc_i  in  32  current PC-register value.
REQ-005 The block SHALL expose these ports: branch_i  in  1  taken branch resolved in ID; branch_target_i  in  32  its target.
REQ-006 The block SHALL expose these ports: jump_i  in  1  jump decoded in ID; jump_target_i  in  32  its target.
REQ-007 The block SHALL expose these ports: idex_memread_i  in  1, idex_rt_i  in  5  load destination in EX; ifid_rs_i, ifid_rt_i  in  5 each  ID source registers.
REQ-008 The block SHALL expose these ports: mem_stall_i  in  1  data memory busy.
REQ-009 The block SHALL expose these ports: pc_next_o  out  32  next PC for the PC register; pc_write_o  out  1  PC write enable.
REQ-010 The block SHALL expose these ports: ifid_write_o  out  1, ifid_flush_o  out  1, idex_bubble_o  out  1  pipeline-register controls.
REQ-011 The block SHALL expose these ports: state_o  out  2  FSM state; stall_cnt_o  out  16  stall cycles; redir_cnt_o  out  16  redirects taken.

Function
REQ-012 The FSM SHALL have the states IDLE=0, RUN=1, MEM=2 and HAZ=3.
REQ-013 IDLE SHALL go to RUN on the first edge where start_i=1; any state except MEM SHALL go to IDLE on an edge where start_i=0.
REQ-014 The block SHALL compute load-use hazard (lu) combinationally: idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
REQ-015 Priority per cycle in RUN SHALL be: mem_stall_i > lu > jump_i > branch_i > sequential.
REQ-016 RUN with mem_stall_i=1 SHALL give pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, flush=0, and the next state SHALL be MEM.
REQ-017 MEM SHALL hold all pipeline controls low while mem_stall_i=1 and SHALL return to RUN on the first edge where mem_stall_i=0; start_i SHALL be ignored while in MEM.
REQ-018 RUN with lu=1 and mem_stall_i=0 SHALL give pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, and the next state SHALL be HAZ.
REQ-019 HAZ SHALL last exactly one cycle with normal RUN output evaluation and SHALL return to RUN; a second lu in HAZ SHALL re-enter HAZ.
REQ-020 A redirect (jump_i or branch_i with no stall) SHALL give pc_next_o = the selected target, pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
REQ-021 When jump_i and branch_i are both 1, jump_target_i SHALL win.
REQ-022 In the sequential case pc_next_o SHALL equal pc_i+32'd4, modulo 2^32 (0xFFFFFFFC -> 0x00000000), with pc_write_o=1 and ifid_write_o=1.
REQ-023 In IDLE the block SHALL drive pc_write_o=0, ifid_write_o=0, ifid_flush_o=0 and idex_bubble_o=0, with pc_next_o=pc_i.
REQ-024 A redirect coinciding with a stall SHALL NOT be latched; the ID stage SHALL re-present it after the stall.
REQ-025 stall_cnt_o SHALL increment on each cycle in which mem-stall or lu suppresses pc_write_o in RUN, MEM or HAZ, and SHALL saturate at 16'hFFFF.
REQ-026 redir_cnt_o SHALL increment on each cycle in which ifid_flush_o=1, and SHALL saturate at 16'hFFFF.
REQ-027 All control outputs SHALL be combinational from state and inputs; the state and counters SHALL be registered.

Reset
REQ-028 rst_i=0 SHALL immediately force state IDLE, stall_cnt_o=0 and redir_cnt_o=0, independent of clk_i, including mid-stall or mid-redirect.
REQ-029 After rst_i rises, the first state change SHALL occur only on a clock edge with start_i=1.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE/RUN/MEM/HAZ), PC_STEP=4, the 32-bit width and the 5-bit register-index width.
REQ-031 The hazard comparator SHALL be a sub-module hazard_detect (inputs memread, rt, rs, rt_id; output lu).
REQ-032 The saturating counters SHALL share one sub-module, sat_cnt16.

Verification
REQ-033 Scenario: reset, then start_i=1 with pc_i=0x00000000 -> state_o=RUN after 1 edge, pc_next_o=0x00000004, pc_write_o=1.
REQ-034 Scenario: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 -> same cycle pc_write_o=0, idex_bubble_o=1; next cycle state_o=HAZ; stall_cnt_o=1; with idex_rt_i=0 -> no stall.
REQ-035 Scenario: mem_stall_i high for 3 cycles -> state_o=MEM for 3 cycles, pc_write_o=0 throughout, stall_cnt_o=3, RUN on the first low edge.
REQ-036 Scenario: jump_i=1 with jump_target_i=0x100 and branch_i=1 with branch_target_i=0x200 -> pc_next_o=0x100, ifid_flush_o=1, redir_cnt_o=1.
REQ-037 Scenario: pc_i=0xFFFFFFFC sequential -> pc_next_o=0x00000000.
REQ-038 Scenario: rst_i low mid-MEM -> immediate IDLE and counters 0; start_i=0 in RUN -> IDLE on the next edge, pc_write_o=0.
